thread_scheduler: RTL and testbench
===================================

THREAD_SCHEDULER -- requirements
Module: thread_scheduler

Interface
REQ-001 Parameter NTHREADS, default 8: number of hardware threads; power of two, 2..8.
REQ-002 Parameter TW, default 3: thread-id width, log2(NTHREADS).
REQ-003 Parameter REISSUE_GAP, default 4: minimum cycles between two issues of the same thread, 1..15.
REQ-004 Parameter RESET_MASK, default 1: active-thread mask loaded at reset.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start_valid  input  1  activate thread start_tid this cycle.
REQ-008 start_tid  input  TW  thread to activate.
REQ-009 halt_valid  input  1  deactivate thread halt_tid this cycle.
REQ-010 halt_tid  input  TW  thread to deactivate.
REQ-011 thread_stall  input  NTHREADS  per-thread block; a set bit makes that thread ineligible.
REQ-012 global_stall  input  1  pipeline freeze; scheduling state holds.
REQ-013 sel  output  TW  thread id presented to fetch (PC read select).
REQ-014 issue_valid  output  1  1 = sel is a real issue; 0 = bubble, fetch injects NOP.
REQ-015 active_mask  output  NTHREADS  current active threads.
REQ-016 idle  output  1  1 when active_mask is all zero.

Function
REQ-017 sel and issue_valid shall be registered; the decision made at edge k from state and inputs sampled at edge k shall appear in cycle k+1.
REQ-018 Thread i is eligible at an edge iff active_mask[i]=1, thread_stall[i]=0 and cooldown[i]=0.
REQ-019 Selection shall be round-robin: first eligible thread scanning from last_issued+1 upward, wrapping NTHREADS-1 -> 0.
REQ-020 If any thread is eligible: issue_valid<=1, sel<=chosen id, last_issued<=chosen id, cooldown[chosen]<=REISSUE_GAP-1.
REQ-021 If no thread is eligible: issue_valid<=0, sel<=last_issued, last_issued unchanged.
REQ-022 Each nonzero cooldown not reloaded at an edge shall decrement by 1; a thread issued in cycle t shall not issue again before cycle t+REISSUE_GAP.
REQ-023 Cooldown shall keep counting while its thread is stalled or halted.
REQ-024 global_stall=1 at an edge: sel, issue_valid, last_issued and all cooldowns hold; start/halt still update active_mask.
REQ-025 start_valid sets active_mask[start_tid]; halt_valid clears active_mask[halt_tid]; both on same tid, halt wins; different tids, both apply.
REQ-026 active_mask changes take effect for eligibility at the following edge, not the same edge.
REQ-027 Halting the thread currently presented on sel shall not retract that issue.
REQ-028 idle shall be combinational from active_mask.

Reset
REQ-029 While reset=0: active_mask=RESET_MASK, sel=0, issue_valid=0, last_issued=NTHREADS-1, all cooldowns=0.
REQ-030 Reset assertion mid-operation shall take effect immediately, independent of clk; first issue after release goes to the lowest-numbered eligible thread.

Configuration
REQ-031 Macro THREAD_SCHED_PRIO_EN defined: extra input hi_prio (NTHREADS); if any eligible thread has hi_prio set, choose round-robin among those only, else among all eligible.
REQ-032 Macro undefined: hi_prio port absent; pure round-robin per REQ-019.

Verification
REQ-033 NTHREADS=8, RESET_MASK=8'hFF, no stalls -> issue_valid=1 every cycle from the first cycle after reset release, sel=0,1,...,7,0 repeating.
REQ-034 RESET_MASK=1, no stalls -> sel=0 with issue_valid=1 once every 4 cycles, issue_valid=0 in the three cycles between.
REQ-035 Mask 8'hFF, thread_stall=8'h04 held -> sequence 0,1,3,4,5,6,7,0; release stall -> thread 2 issued on its next round-robin turn.
REQ-036 global_stall=1 for 3 cycles mid-stream with sel=5 -> sel=5, issue_valid=1 held; after release next sel=6.
REQ-037 start_valid and halt_valid both with tid=3, thread 3 inactive -> active_mask[3] stays 0; halt of all threads -> idle=1, issue_valid=0 from the second cycle after the halt edge.
REQ-038 THREAD_SCHED_PRIO_EN, mask 8'hFF, hi_prio=8'h30 -> issues alternate 4,5 until cooldown blocks them, bubbles filled by lowest-priority round-robin threads.

Source files
------------

// File: rtl/thread_scheduler.sv
// Round-robin fine-grained thread scheduler with per-thread reissue cooldown.
// Optional hi_prio port and priority filtering under THREAD_SCHED_PRIO_EN.
module thread_scheduler #(
    parameter int NTHREADS = 8,
    parameter int TW = 3,
    parameter int REISSUE_GAP = 4,
    parameter logic [NTHREADS-1:0] RESET_MASK = NTHREADS'(1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_valid,
    input  logic [TW-1:0]       start_tid,
    input  logic                halt_valid,
    input  logic [TW-1:0]       halt_tid,
    input  logic [NTHREADS-1:0] thread_stall,
    input  logic                global_stall,
`ifdef THREAD_SCHED_PRIO_EN
    input  logic [NTHREADS-1:0] hi_prio,
`endif
    output logic [TW-1:0]       sel,
    output logic                issue_valid,
    output logic [NTHREADS-1:0] active_mask,
    output logic                idle
);

    localparam int CW = 4;
    localparam logic [CW-1:0] GAP_LOAD = CW'(REISSUE_GAP - 1);

    logic [TW-1:0]       last;
    logic [CW-1:0]       cd [NTHREADS];
    logic [NTHREADS-1:0] elig;
    logic [NTHREADS-1:0] cand;
    logic [NTHREADS-1:0] mask_nxt;
    logic                pick_ok;
    logic [TW-1:0]       pick;
    logic [TW-1:0]       idx;

    // Eligibility: active, not blocked, cooldown expired.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NTHREADS; i++) begin
            elig[i] = active_mask[i] & ~thread_stall[i] & (cd[i] == '0);
        end
    end

    // Candidate set: high-priority eligible threads win when present.
    always_comb begin
        cand = elig;
`ifdef THREAD_SCHED_PRIO_EN
        if (|(elig & hi_prio)) begin
            cand = elig & hi_prio;
        end
`endif
    end

    // Round-robin scan starting just past the last issued thread.
    always_comb begin
        pick_ok = 1'b0;
        pick    = last;
        idx     = last;
        for (int k = 1; k <= NTHREADS; k++) begin
            idx = last + TW'(k);
            if (!pick_ok && cand[idx]) begin
                pick_ok = 1'b1;
                pick    = idx;
            end
        end
    end

    // Next active mask; halt overrides start on the same thread.
    always_comb begin
        mask_nxt = active_mask;
        if (start_valid) begin
            mask_nxt[start_tid] = 1'b1;
        end
        if (halt_valid) begin
            mask_nxt[halt_tid] = 1'b0;
        end
    end

    // Active mask register; keeps updating through a pipeline freeze.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_mask <= RESET_MASK;
        end else begin
            active_mask <= mask_nxt;
        end
    end

    // Registered issue decision; bubbles keep sel on the last issued thread.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel         <= '0;
            issue_valid <= 1'b0;
            last        <= TW'(NTHREADS - 1);
        end else if (!global_stall) begin
            issue_valid <= pick_ok;
            if (pick_ok) begin
                sel  <= pick;
                last <= pick;
            end else begin
                sel  <= last;
            end
        end
    end

    // Per-thread cooldown: reload on issue, else count down to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NTHREADS; i++) begin
                cd[i] <= '0;
            end
        end else if (!global_stall) begin
            for (int i = 0; i < NTHREADS; i++) begin
                if (pick_ok && (pick == TW'(i))) begin
                    cd[i] <= GAP_LOAD;
                end else if (cd[i] != '0) begin
                    cd[i] <= cd[i] - 1'b1;
                end
            end
        end
    end

    assign idle = ~|active_mask;

endmodule

// File: tb/tb_thread_scheduler.sv
// Scoreboard bench for thread_scheduler: directed vectors push expected
// outputs, an independent monitor pops and compares each cycle.
module tb_thread_scheduler;

    logic       clk;
    logic       reset;
    logic       start_valid;
    logic [2:0] start_tid;
    logic       halt_valid;
    logic [2:0] halt_tid;
    logic [7:0] thread_stall;
    logic       global_stall;
`ifdef THREAD_SCHED_PRIO_EN
    logic [7:0] hi_prio;
`endif
    logic [2:0] sel;
    logic       issue_valid;
    logic [7:0] active_mask;
    logic       idle;

    typedef struct packed {
        int         id;
        logic       v;
        logic [2:0] sel;
        logic [7:0] mask;
        logic       idle;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   step_id = 0;

    thread_scheduler #(
        .NTHREADS(8),
        .TW(3),
        .REISSUE_GAP(4),
        .RESET_MASK(8'h01)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_valid(start_valid),
        .start_tid(start_tid),
        .halt_valid(halt_valid),
        .halt_tid(halt_tid),
        .thread_stall(thread_stall),
        .global_stall(global_stall),
`ifdef THREAD_SCHED_PRIO_EN
        .hi_prio(hi_prio),
`endif
        .sel(sel),
        .issue_valid(issue_valid),
        .active_mask(active_mask),
        .idle(idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compare the DUT outputs for every expected entry.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if ({issue_valid, sel, active_mask, idle} !==
                {e.v, e.sel, e.mask, e.idle}) begin
                bad++;
                $display("FAIL step%0d: got v=%0b sel=%0d mask=%h idle=%0b want v=%0b sel=%0d mask=%h idle=%0b",
                         e.id, issue_valid, sel, active_mask, idle,
                         e.v, e.sel, e.mask, e.idle);
            end
        end
    end

    task automatic vec(input bit rs, input bit sv, input int st,
                       input bit hv, input int ht, input int ts,
                       input bit gs, input bit ev, input int es,
                       input int em);
        exp_t x;
        @(negedge clk);
        reset        = rs;
        start_valid  = sv;
        start_tid    = 3'(st);
        halt_valid   = hv;
        halt_tid     = 3'(ht);
        thread_stall = 8'(ts);
        global_stall = gs;
        step_id++;
        x.id   = step_id;
        x.v    = ev;
        x.sel  = 3'(es);
        x.mask = 8'(em);
        x.idle = (8'(em) == 8'h00);
        exp_q.push_back(x);
    endtask

    int dseq[10] = '{7, 0, 1, 2, 3, 4, 5, 6, 7, 0};
    int eseq[7]  = '{1, 3, 4, 5, 6, 7, 0};

    initial begin
        reset        = 1'b0;
        start_valid  = 1'b0;
        start_tid    = '0;
        halt_valid   = 1'b0;
        halt_tid     = '0;
        thread_stall = '0;
        global_stall = 1'b0;
`ifdef THREAD_SCHED_PRIO_EN
        hi_prio      = '0;
`endif
        // reset state
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h01);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h01);
        // single thread: one issue every 4 cycles
        vec(1, 0, 0, 0, 0, 0, 0, 1, 0, 'h01);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h01);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h01);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h01);
        vec(1, 0, 0, 0, 0, 0, 0, 1, 0, 'h01);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h01);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h01);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h01);
        // start threads 1..7; a start is seen one edge later
        vec(1, 1, 1, 0, 0, 0, 0, 1, 0, 'h03);
        vec(1, 1, 2, 0, 0, 0, 0, 1, 1, 'h07);
        vec(1, 1, 3, 0, 0, 0, 0, 1, 2, 'h0F);
        vec(1, 1, 4, 0, 0, 0, 0, 1, 3, 'h1F);
        vec(1, 1, 5, 0, 0, 0, 0, 1, 4, 'h3F);
        vec(1, 1, 6, 0, 0, 0, 0, 1, 5, 'h7F);
        vec(1, 1, 7, 0, 0, 0, 0, 1, 6, 'hFF);
        // all active, full round-robin
        for (int i = 0; i < 10; i++) begin
            vec(1, 0, 0, 0, 0, 0, 0, 1, dseq[i], 'hFF);
        end
        // thread 2 blocked
        for (int i = 0; i < 7; i++) begin
            vec(1, 0, 0, 0, 0, 'h04, 0, 1, eseq[i], 'hFF);
        end
        // unblock: thread 2 gets its turn
        vec(1, 0, 0, 0, 0, 0, 0, 1, 1, 'hFF);
        vec(1, 0, 0, 0, 0, 0, 0, 1, 2, 'hFF);
        vec(1, 0, 0, 0, 0, 0, 0, 1, 3, 'hFF);
        // pipeline freeze holding sel=5
        vec(1, 0, 0, 0, 0, 0, 0, 1, 4, 'hFF);
        vec(1, 0, 0, 0, 0, 0, 0, 1, 5, 'hFF);
        vec(1, 0, 0, 0, 0, 0, 1, 1, 5, 'hFF);
        vec(1, 0, 0, 0, 0, 0, 1, 1, 5, 'hFF);
        vec(1, 0, 0, 0, 0, 0, 1, 1, 5, 'hFF);
        vec(1, 0, 0, 0, 0, 0, 0, 1, 6, 'hFF);
        vec(1, 0, 0, 0, 0, 0, 0, 1, 7, 'hFF);
        // halt 3, then start+halt 3 together keeps it off
        vec(1, 0, 0, 1, 3, 0, 0, 1, 0, 'hF7);
        vec(1, 1, 3, 1, 3, 0, 0, 1, 1, 'hF7);
        // halt the rest one by one
        vec(1, 0, 0, 1, 0, 0, 0, 1, 2, 'hF6);
        vec(1, 0, 0, 1, 1, 0, 0, 1, 4, 'hF4);
        vec(1, 0, 0, 1, 2, 0, 0, 1, 5, 'hF0);
        vec(1, 0, 0, 1, 4, 0, 0, 1, 6, 'hE0);
        vec(1, 0, 0, 1, 5, 0, 0, 1, 7, 'hC0);
        vec(1, 0, 0, 1, 6, 0, 0, 0, 7, 'h80);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 7, 'h80);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 7, 'h80);
        // halting the issuing thread does not retract its issue
        vec(1, 0, 0, 1, 7, 0, 0, 1, 7, 'h00);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 7, 'h00);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 7, 'h00);
        // restart from idle
        vec(1, 1, 2, 0, 0, 0, 0, 0, 7, 'h04);
        vec(1, 1, 5, 0, 0, 0, 0, 1, 2, 'h24);
        vec(1, 0, 0, 0, 0, 0, 0, 1, 5, 'h24);
        // asynchronous reset between clock edges
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({issue_valid, sel, active_mask, idle} !== {1'b0, 3'd0, 8'h01, 1'b0}) begin
            bad++;
            $display("FAIL async_reset: got v=%0b sel=%0d mask=%h idle=%0b want v=0 sel=0 mask=01 idle=0",
                     issue_valid, sel, active_mask, idle);
        end
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h01);
        // first issue after release goes to lowest eligible thread
        vec(1, 1, 3, 0, 0, 0, 0, 1, 0, 'h09);
        vec(1, 0, 0, 0, 0, 0, 0, 1, 3, 'h09);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 3, 'h09);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 3, 'h09);
        vec(1, 0, 0, 0, 0, 0, 0, 1, 0, 'h09);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
